gate_vector_sweeper: RTL

Sequential stimulus-and-capture stage placed directly upstream of a combinational gate under test, such as the two-input NAND. On a start pulse it drives every input vector onto the gate in ascending binary order and holds each vector for a programmable settle time. It samples the gate output into a truth-table register and can optionally compare each sample against the expected NAND value. It replaces hand-written per-vector testbench sequences with one reusable clocked block.

---
 rtl/gate_test_pkg.sv | 28 ++
 rtl/gate_vector_sweeper_settle_ctr.sv | 29 ++
 rtl/gate_vector_sweeper.sv | 126 ++++++++++++
 3 files changed

// File: rtl/gate_test_pkg.sv
// Shared types and helpers for the gate vector sweeper: FSM states,
// expected NAND value and settle counter width rule.
package gate_test_pkg;

    localparam int unsigned MAX_N_IN = 6;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        DONE
    } sweep_state_e;

    function automatic int unsigned settle_cw(input int unsigned settle);
        return $clog2(settle + 1);
    endfunction

    // Only the low n bits of v are real gate inputs.
    function automatic logic nand_expect(input logic [MAX_N_IN-1:0] v,
                                         input int unsigned n);
        logic all_ones;
        all_ones = 1'b1;
        for (int unsigned i = 0; i < MAX_N_IN; i++) begin
            if (i < n) all_ones = all_ones & v[i];
        end
        return ~all_ones;
    endfunction

endpackage

// File: rtl/gate_vector_sweeper_settle_ctr.sv
// Settle counter: counts while enabled, wraps to zero on terminal count
// (SETTLE-1) and exposes the terminal count combinationally.
module sweep_settle_ctr
    import gate_test_pkg::*;
#(
    parameter int unsigned SETTLE = 1,
    parameter int unsigned CW     = settle_cw(SETTLE)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tc
);

    logic [CW-1:0] cnt;

    assign tc = (cnt == CW'(SETTLE - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (en) begin
            if (tc) cnt <= '0;
            else    cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/gate_vector_sweeper.sv
// Drives every input vector onto a gate under test and captures its truth
// table. GATE_SWEEP_CHECK_EN builds in the comparison against NAND.
module gate_vector_sweeper
    import gate_test_pkg::*;
#(
    parameter int unsigned N_IN   = 2,
    parameter int unsigned SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  y,
    output logic [N_IN-1:0]       vec,
    output logic                  busy,
    output logic                  done,
    output logic [(1<<N_IN)-1:0]  truth_tbl,
    output logic [N_IN:0]         err_count,
    output logic [N_IN-1:0]       first_fail,
    output logic                  pass
);

    localparam int unsigned N_VEC = 1 << N_IN;

    sweep_state_e state_q, state_d;
    logic         tc;
    logic         last;

    assign last = &vec;

    sweep_settle_ctr #(
        .SETTLE (SETTLE)
    ) u_settle (
        .clk   (clk),
        .rst   (rst),
        .clear (state_q == IDLE),
        .en    (state_q == DRIVE),
        .tc    (tc)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = DRIVE;
            DRIVE:   if (tc && last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            truth_tbl <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        truth_tbl <= '0;
                        vec       <= '0;
                        busy      <= 1'b1;
                    end
                end
                DRIVE: begin
                    if (tc) begin
                        truth_tbl[vec] <= y;
                        if (last) begin
                            busy <= 1'b0;
                            done <= 1'b1;
                        end else begin
                            vec <= vec + 1'b1;
                        end
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    vec  <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef GATE_SWEEP_CHECK_EN
    logic [MAX_N_IN-1:0] vec_ext;
    logic                mismatch;
    logic                err_inc;
    logic [N_IN:0]       err_next;

    always_comb begin
        vec_ext           = '0;
        vec_ext[N_IN-1:0] = vec;
        mismatch          = (y != nand_expect(vec_ext, N_IN));
        err_inc           = mismatch && (err_count != (N_IN+1)'(N_VEC));
        err_next          = err_count + {{N_IN{1'b0}}, err_inc};
    end

    // pass is latched from err_next so the final vector's comparison counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count  <= '0;
            first_fail <= '0;
            pass       <= 1'b0;
        end else if (state_q == IDLE && start) begin
            err_count  <= '0;
            first_fail <= '0;
            pass       <= 1'b0;
        end else if (state_q == DRIVE && tc) begin
            err_count <= err_next;
            if (mismatch && err_count == '0) first_fail <= vec;
            if (last) pass <= (err_next == '0);
        end
    end
`else
    assign err_count  = '0;
    assign first_fail = '0;
    assign pass       = 1'b0;
`endif

endmodule
